// File: rtl/servo_flip_ctrl_if.sv
// Register-side bundle for the servo flip sequencer: per-channel request
// strobes and counts in, per-channel set-points and status out.
interface servo_flip_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int POS_W  = 8
);
  // Handshake: start[i] is a one-cycle strobe. It is taken only when busy[i]
  // is low; while busy[i] is high it is ignored. done[i] pulses for one cycle
  // when a channel finishes its flips, is aborted, or is given a zero count.
  // abort[i] is a one-cycle strobe that only acts while busy[i] is high.
  logic                    enable;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH*CNT_W-1:0] flip_count;
  logic [NUM_CH-1:0]       abort;
  logic [NUM_CH*POS_W-1:0] motorposition;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;

  // Processor / register side
  modport master (
    output enable, start, flip_count, abort,
    input  motorposition, busy, done
  );

  // Sequencer side
  modport slave (
    input  enable, start, flip_count, abort,
    output motorposition, busy, done
  );
endinterface

// File: rtl/servo_flip_ctrl.sv
// Multi-channel servo position sequencer. A shared interval timer produces a
// tick; each channel toggles its set-point between POS_A and POS_B once per
// tick until its requested flip count is used up, then pulses done.
module servo_flip_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int POS_W       = 8,
  parameter int POS_A       = 90,
  parameter int POS_B       = 20,
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  servo_flip_ctrl_if.slave  bus,
  output logic [NUM_CH-1:0] ch_state
);

  // Per-channel FSM encoding; ch_state exposes each channel's state bit.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0]    tick_last = TW'(TICK_CYCLES - 1);
  localparam logic [POS_W-1:0] pos_a     = POS_W'(POS_A);
  localparam logic [POS_W-1:0] pos_b     = POS_W'(POS_B);

  logic [TW-1:0]    tcnt;
  logic             tick;
  logic [0:0]       state_q [NUM_CH];
  logic [CNT_W-1:0] rem_q   [NUM_CH];
  logic [POS_W-1:0] pos_q   [NUM_CH];
  logic [NUM_CH-1:0] done_q;

  // Tick is only meaningful while enabled; a paused timer never fires.
  assign tick = bus.enable && (tcnt == tick_last);

  // Interval timer: free-runs 0..TICK_CYCLES-1 while enabled, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
    end else if (bus.enable) begin
      if (tcnt == tick_last) tcnt <= '0;
      else                   tcnt <= tcnt + 1'b1;
    end
  end

  // Channel sequencers: load on start, toggle per tick, finish or abort.
  // A tick in the load cycle is not applied because the channel is still
  // IDLE in that cycle; the first toggle lands on the next tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        rem_q[i]   <= '0;
        pos_q[i]   <= pos_a;
      end
      done_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        done_q[i] <= 1'b0;
        case (state_q[i])
          IDLE: begin
            if (bus.start[i]) begin
              if (bus.flip_count[i*CNT_W +: CNT_W] == '0) begin
                // Empty request completes immediately without motion.
                done_q[i] <= 1'b1;
              end else begin
                rem_q[i]   <= bus.flip_count[i*CNT_W +: CNT_W];
                state_q[i] <= RUN;
              end
            end
          end
          RUN: begin
            if (bus.abort[i]) begin
              // Abort beats a coincident tick: no toggle on that edge.
              rem_q[i]   <= '0;
              state_q[i] <= IDLE;
              done_q[i]  <= 1'b1;
            end else if (tick) begin
              pos_q[i] <= (pos_q[i] == pos_a) ? pos_b : pos_a;
              rem_q[i] <= rem_q[i] - 1'b1;
              if (rem_q[i] == CNT_W'(1)) begin
                state_q[i] <= IDLE;
                done_q[i]  <= 1'b1;
              end
            end
          end
          default: begin
            state_q[i] <= IDLE;
            rem_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Pack the registered per-channel state onto the output buses.
  always_comb begin
    bus.motorposition = '0;
    bus.busy          = '0;
    ch_state          = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.motorposition[i*POS_W +: POS_W] = pos_q[i];
      bus.busy[i]                         = (state_q[i] == RUN);
      ch_state[i]                         = state_q[i][0];
    end
  end

  assign bus.done = done_q;

endmodule

// File: doc/servo_flip_ctrl.md
Name: servo_flip_ctrl

Overview:
Parametrised, multi-channel servo position sequencer. It is the successor to the fixed four-channel half-second flipper.
- Each channel accepts a flip-count request and toggles its servo position between two set-points once per shared tick until the count is exhausted.
- Each channel reports busy and done.
- It sits between the processor register interface and the servo PWM generators.

Parameters:
NUM_CH, 4, number of independent servo channels
CNT_W, 8, width of per-channel flip count
POS_W, 8, width of position output per channel
POS_A, 90, home/reset set-point
POS_B, 20, alternate set-point
TICK_CYCLES, 50_000_000, clk cycles per flip interval (0.5 s at 100 MHz); must be >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-high reset
enable  input  1  high: interval timer runs; low: timer and all sequencing pause, state held
start  input  NUM_CH  per-channel one-cycle load strobe
flip_count  input  NUM_CH*CNT_W  per-channel flip count; channel i in bits [i*CNT_W +: CNT_W]
abort  input  NUM_CH  per-channel cancel strobe
motorposition  output  NUM_CH*POS_W  per-channel set-point; channel i in bits [i*POS_W +: POS_W]
busy  output  NUM_CH  channel has flips remaining
done  output  NUM_CH  one-cycle pulse when a channel completes or aborts

Behaviour:
Reset (sync, highest priority):
- All motorposition = POS_A; busy = 0; done = 0; remaining counters = 0; tick counter = 0.
- Reset asserted mid-sequence discards all pending flips with no done pulse.

Tick generator:
- Counter tcnt counts 0..TICK_CYCLES-1 while enable = 1.
- Internal tick is high in the cycle where tcnt == TICK_CYCLES-1 and enable = 1; tcnt wraps to 0 on that edge.
- enable = 0: tcnt holds and tick = 0.

Per-channel FSM, states IDLE and RUN (busy = state==RUN):
IDLE:
- start[i] = 1 and flip_count_i != 0: latch remaining = flip_count_i, go RUN at the next edge.
- start[i] = 1 and flip_count_i == 0: stay IDLE, done[i] pulses high the next cycle, position unchanged.
- start is accepted regardless of enable.
RUN:
- On each tick, position toggles: if current == POS_A then POS_B, else POS_A.
- On the same tick, remaining decrements.
- Tick with remaining == 1: toggle, remaining -> 0, state -> IDLE, done[i] = 1 for exactly one cycle (registered at the same edge).
- start[i] while RUN is ignored; the count is not reloaded.
- abort[i] while RUN: remaining -> 0, IDLE, done[i] pulse next cycle, position holds its current value, no further toggles.
- abort and tick in the same cycle: abort wins, no toggle.
- abort while IDLE: no effect.

Timing and independence:
- A tick in the same cycle as the start strobe is not applied to the new request; the first toggle occurs on the first tick strictly after busy rises.
- Channels are fully independent and share only the tick.
- Simultaneous completions assert multiple done bits in the same cycle.
- A final position is POS_B for odd counts and POS_A for even counts, starting from POS_A.

Width rules:
- remaining is CNT_W bits unsigned; count 2^CNT_W-1 yields that many flips with no wrap.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. TICK_CYCLES=4, enable=1, start[0] with count 3 -> busy[0] rises 1 cycle later; motorposition0 goes 20,90,20 on ticks 4 cycles apart; done[0] pulses once as busy falls; final value 20.
2. Channels 0..3 started in the same cycle with counts 1,2,0,5 -> ch2 done next cycle with no motion; ch0 done after 1 tick, ch1 after 2, ch3 after 5; final positions 20,90,90,20.
3. Drop enable for 10 cycles mid-sequence on ch1 (count 4) -> no toggles and tcnt frozen while low; the remaining 4-k flips complete after re-enable with unchanged 4-cycle spacing.
4. Start ch0 with count 6, abort after 2 toggles; separately, abort coinciding with a tick -> position holds at 90 with no further toggles, done pulse next cycle; in the coincident case there is no toggle on that tick.
5. Assert reset while ch0 is RUN with count 5 at position 20 -> next cycle position 90, busy 0, no done pulse; re-start with count 2 works normally.
6. Re-strobe start[0] with count 7 while RUN (original count 2) -> ignored; exactly 2 toggles occur, then done.
